dispatch_credit_tracker: RTL and testbench
==========================================

DISPATCH_CREDIT_TRACKER -- requirements
Module: dispatch_credit_tracker

Interface
REQ-001 SHALL have these parameters (name, default, meaning): DISPATCH_WIDTH, 4, lanes per bundle; ISSUE_WIDTH, 4, max IQ entries freed per cycle; COMMIT_WIDTH, 4, max ROB/LDQ/STQ entries freed per cycle; IQ_SIZE, 32; ROB_SIZE, 64; LDQ_SIZE, 16; STQ_SIZE, 16; DRAIN_CYCLES, 2, post-flush dispatch blackout.
REQ-002 SHALL have these ports (name  direction  width  meaning): clk  in  1  sole clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: flush_i  in  1  backend flush; stall_i  in  1  external downstream stall; renameReady_i  in  1  valid bundle present from the rename/dispatch pipeline register.
REQ-004 SHALL have per-lane ports (each DISPATCH_WIDTH wide): laneValid_i, isLoad_i, isStore_i, skipIQ_i.
REQ-005 SHALL have release ports: iqFreed_i  in  clog2(ISSUE_WIDTH+1); robFreed_i, ldqFreed_i, stqFreed_i  in  clog2(COMMIT_WIDTH+1).
REQ-006 SHALL have outputs: backEndReady_o  1  bundle dispatched this cycle; resStall_o  1  stall due to credits or drain; iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o  clog2(SIZE+1) each  current free counts; state_o  2  FSM state; creditErr_o  1  sticky over-release flag; stallCycles_o  32  saturating stall counter.

Function
REQ-007 Lane counted only if laneValid_i[i]=1; robNeed = counted lanes; iqNeed = counted lanes with skipIQ_i=0; ldqNeed = counted lanes with isLoad_i=1; stqNeed = counted lanes with isStore_i=1.
REQ-008 fits SHALL be 1 iff robNeed<=robCredit, iqNeed<=iqCredit, ldqNeed<=ldqCredit and stqNeed<=stqCredit, using registered credits only.
REQ-009 backEndReady_o SHALL be combinational: renameReady_i & ~stall_i & ~flush_i & fits & (state==RUN or state==RSTALL).
REQ-010 Dispatch SHALL be all-or-nothing; no partial-bundle dispatch.
REQ-011 Each credit SHALL update at the clock edge: next = credit - (backEndReady_o ? need : 0) + freed; freed inputs never affect the same-cycle fits check.
REQ-012 If next exceeds SIZE, credit SHALL clamp to SIZE and creditErr_o SHALL set and stay set until reset.
REQ-013 Underflow SHALL be impossible by construction (REQ-008); no wrap-around permitted.
REQ-014 FSM states: RUN=0, RSTALL=1, DRAIN=2; encoding 3 unused and SHALL map to RUN.
REQ-015 RUN->RSTALL when renameReady_i & ~stall_i & ~fits; RSTALL->RUN on a cycle where backEndReady_o=1 or renameReady_i=0.
REQ-016 flush_i=1 in any state SHALL, next edge: all credits to SIZE, state to DRAIN, drain counter to DRAIN_CYCLES-1; flush takes priority over dispatch and release in that cycle.
REQ-017 DRAIN SHALL hold backEndReady_o=0 for exactly DRAIN_CYCLES cycles after the flush edge, then go to RUN; a flush during DRAIN restarts the count.
REQ-018 resStall_o SHALL be 1 when renameReady_i & ~stall_i & ~flush_i & ~backEndReady_o; it is 0 otherwise.
REQ-019 stallCycles_o SHALL increment on each cycle with resStall_o=1, saturating at 32'hFFFF_FFFF; it is not cleared by flush.

Reset
REQ-020 reset=0 SHALL asynchronously force: all credits to SIZE, state RUN, drain counter 0, creditErr_o 0, stallCycles_o 0.
REQ-021 backEndReady_o SHALL be 0 while reset=0 regardless of other inputs; reset deassertion mid-bundle SHALL require no handshake replay.

Verification
REQ-022 Reset, then 4 valid lanes (2 loads, 1 store, 1 skipIQ), renameReady_i=1 -> backEndReady_o=1 same cycle; next cycle rob=60, iq=29, ldq=14, stq=15.
REQ-023 Fill LDQ to 1 credit, bundle with 2 loads -> backEndReady_o=0, resStall_o=1, state RSTALL; ldqFreed_i=1 -> dispatch on following cycle, state RUN.
REQ-024 Dispatch full 4-lane bundle with iqFreed_i=4 in same cycle at iq=4 -> dispatch; iq stays 4 next cycle.
REQ-025 Assert flush_i with credits partly used and renameReady_i=1 -> no dispatch that cycle, credits = SIZE next cycle, backEndReady_o=0 for 2 cycles, dispatch on 3rd.
REQ-026 At stq=STQ_SIZE, stqFreed_i=1 -> stq stays 16, creditErr_o=1 and persists until reset.
REQ-027 Assert reset mid-RSTALL -> outputs immediately at reset values; stallCycles_o=0.

Source files
------------

// File: rtl/dispatch_credit_tracker.sv
// Credit-based dispatch gate: counts free IQ/ROB/LDQ/STQ entries and lets a rename bundle
// dispatch only when every lane in it can be accepted at once.
module dispatch_credit_tracker #(
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned ISSUE_WIDTH    = 4,
  parameter int unsigned COMMIT_WIDTH   = 4,
  parameter int unsigned IQ_SIZE        = 32,
  parameter int unsigned ROB_SIZE       = 64,
  parameter int unsigned LDQ_SIZE       = 16,
  parameter int unsigned STQ_SIZE       = 16,
  parameter int unsigned DRAIN_CYCLES   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush_i,
  input  logic                                stall_i,
  input  logic                                renameReady_i,
  input  logic [DISPATCH_WIDTH-1:0]           laneValid_i,
  input  logic [DISPATCH_WIDTH-1:0]           isLoad_i,
  input  logic [DISPATCH_WIDTH-1:0]           isStore_i,
  input  logic [DISPATCH_WIDTH-1:0]           skipIQ_i,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]    iqFreed_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]   robFreed_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]   ldqFreed_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]   stqFreed_i,
  output logic                                backEndReady_o,
  output logic                                resStall_o,
  output logic [$clog2(IQ_SIZE+1)-1:0]        iqCredit_o,
  output logic [$clog2(ROB_SIZE+1)-1:0]       robCredit_o,
  output logic [$clog2(LDQ_SIZE+1)-1:0]       ldqCredit_o,
  output logic [$clog2(STQ_SIZE+1)-1:0]       stqCredit_o,
  output logic [1:0]                          state_o,
  output logic                                creditErr_o,
  output logic [31:0]                         stallCycles_o
);

  localparam int unsigned IqW  = $clog2(IQ_SIZE + 1);
  localparam int unsigned RobW = $clog2(ROB_SIZE + 1);
  localparam int unsigned LdqW = $clog2(LDQ_SIZE + 1);
  localparam int unsigned StqW = $clog2(STQ_SIZE + 1);
  localparam int unsigned DcW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StRstall = 2'd1,
    StDrain  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DcW-1:0]  drain_q, drain_d;
  logic [IqW-1:0]  iq_q, iq_d;
  logic [RobW-1:0] rob_q, rob_d;
  logic [LdqW-1:0] ldq_q, ldq_d;
  logic [StqW-1:0] stq_q, stq_d;
  logic            err_q, err_d;
  logic [31:0]     stall_q, stall_d;

  logic [31:0] iq_need, rob_need, ldq_need, stq_need;
  logic        fits, run_like, ready, res_stall, bundle_req;
  logic [32:0] iq_nx, rob_nx, ldq_nx, stq_nx;

  // Returns {overflow, clamped_next}; underflow cannot occur because dispatch requires fits.
  function automatic logic [32:0] credit_next(input logic [31:0] cur, input logic [31:0] used,
                                              input logic [31:0] freed, input logic [31:0] size);
    logic [31:0] v;
    v = cur - used + freed;
    if (v > size) return {1'b1, size};
    return {1'b0, v};
  endfunction

  always_comb begin
    iq_need  = '0;
    rob_need = '0;
    ldq_need = '0;
    stq_need = '0;
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      if (laneValid_i[i]) begin
        rob_need = rob_need + 32'd1;
        if (!skipIQ_i[i]) iq_need  = iq_need + 32'd1;
        if (isLoad_i[i])  ldq_need = ldq_need + 32'd1;
        if (isStore_i[i]) stq_need = stq_need + 32'd1;
      end
    end
  end

  assign fits = (iq_need <= 32'(iq_q)) && (rob_need <= 32'(rob_q)) &&
                (ldq_need <= 32'(ldq_q)) && (stq_need <= 32'(stq_q));

  // The unused encoding 3 behaves as RUN, so only DRAIN blocks dispatch.
  assign run_like   = (state_q != StDrain);
  assign bundle_req = renameReady_i & ~stall_i & ~flush_i;
  assign ready      = reset & bundle_req & fits & run_like;
  assign res_stall  = bundle_req & ~ready;

  assign iq_nx  = credit_next(32'(iq_q),  ready ? iq_need  : 32'd0, 32'(iqFreed_i),  IQ_SIZE);
  assign rob_nx = credit_next(32'(rob_q), ready ? rob_need : 32'd0, 32'(robFreed_i), ROB_SIZE);
  assign ldq_nx = credit_next(32'(ldq_q), ready ? ldq_need : 32'd0, 32'(ldqFreed_i), LDQ_SIZE);
  assign stq_nx = credit_next(32'(stq_q), ready ? stq_need : 32'd0, 32'(stqFreed_i), STQ_SIZE);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    iq_d    = IqW'(iq_nx[31:0]);
    rob_d   = RobW'(rob_nx[31:0]);
    ldq_d   = LdqW'(ldq_nx[31:0]);
    stq_d   = StqW'(stq_nx[31:0]);
    err_d   = err_q | iq_nx[32] | rob_nx[32] | ldq_nx[32] | stq_nx[32];
    stall_d = (res_stall && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;

    if (flush_i) begin
      iq_d    = IqW'(IQ_SIZE);
      rob_d   = RobW'(ROB_SIZE);
      ldq_d   = LdqW'(LDQ_SIZE);
      stq_d   = StqW'(STQ_SIZE);
      err_d   = err_q;
      state_d = StDrain;
      drain_d = DcW'(DRAIN_CYCLES - 1);
    end else begin
      case (state_q)
        StRstall: begin
          if (ready || !renameReady_i) state_d = StRun;
        end
        StDrain: begin
          if (drain_q == '0) state_d = StRun;
          else               drain_d = drain_q - DcW'(1);
        end
        default: begin
          state_d = (renameReady_i && !stall_i && !fits) ? StRstall : StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      drain_q <= '0;
      iq_q    <= IqW'(IQ_SIZE);
      rob_q   <= RobW'(ROB_SIZE);
      ldq_q   <= LdqW'(LDQ_SIZE);
      stq_q   <= StqW'(STQ_SIZE);
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      iq_q    <= iq_d;
      rob_q   <= rob_d;
      ldq_q   <= ldq_d;
      stq_q   <= stq_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign backEndReady_o = ready;
  assign resStall_o     = res_stall;
  assign iqCredit_o     = iq_q;
  assign robCredit_o    = rob_q;
  assign ldqCredit_o    = ldq_q;
  assign stqCredit_o    = stq_q;
  assign state_o        = state_q;
  assign creditErr_o    = err_q;
  assign stallCycles_o  = stall_q;

endmodule

// File: tb/tb_dispatch_credit_tracker.sv
// Bench for dispatch_credit_tracker: directed scenarios plus randomized traffic against a
// free-count model kept as plain integers.
module tb_dispatch_credit_tracker;

  localparam int IQS = 32, ROBS = 64, LDQS = 16, STQS = 16, DRN = 2, W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       flush_i, stall_i, renameReady_i;
  logic [3:0] laneValid_i, isLoad_i, isStore_i, skipIQ_i;
  logic [2:0] iqFreed_i, robFreed_i, ldqFreed_i, stqFreed_i;
  logic       backEndReady_o, resStall_o, creditErr_o;
  logic [5:0] iqCredit_o;
  logic [6:0] robCredit_o;
  logic [4:0] ldqCredit_o, stqCredit_o;
  logic [1:0] state_o;
  logic [31:0] stallCycles_o;

  dispatch_credit_tracker dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .stall_i(stall_i),
    .renameReady_i(renameReady_i), .laneValid_i(laneValid_i), .isLoad_i(isLoad_i),
    .isStore_i(isStore_i), .skipIQ_i(skipIQ_i), .iqFreed_i(iqFreed_i),
    .robFreed_i(robFreed_i), .ldqFreed_i(ldqFreed_i), .stqFreed_i(stqFreed_i),
    .backEndReady_o(backEndReady_o), .resStall_o(resStall_o), .iqCredit_o(iqCredit_o),
    .robCredit_o(robCredit_o), .ldqCredit_o(ldqCredit_o), .stqCredit_o(stqCredit_o),
    .state_o(state_o), .creditErr_o(creditErr_o), .stallCycles_o(stallCycles_o)
  );

  int total = 0;
  int bad = 0;

  // Model: free counts, blackout cycles left after a flush, resource-stall flag.
  int     m_cred[4];
  int     m_size[4] = '{IQS, ROBS, LDQS, STQS};
  int     m_need[4];
  bit     m_fits, m_ready, m_res, m_rstall, m_err;
  int     m_blackout;
  longint m_stall;

  function automatic int m_state();
    return (m_blackout > 0) ? 2 : (m_rstall ? 1 : 0);
  endfunction

  function automatic logic [22:0] m_creds();
    return {6'(m_cred[0]), 7'(m_cred[1]), 5'(m_cred[2]), 5'(m_cred[3])};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m_cred[k] = m_size[k];
    m_rstall = 0; m_err = 0; m_blackout = 0; m_stall = 0;
  endfunction

  function automatic void model_eval();
    for (int k = 0; k < 4; k++) m_need[k] = 0;
    for (int i = 0; i < W; i++) begin
      if (laneValid_i[i]) begin
        m_need[1]++;
        if (!skipIQ_i[i]) m_need[0]++;
        if (isLoad_i[i])  m_need[2]++;
        if (isStore_i[i]) m_need[3]++;
      end
    end
    m_fits = 1;
    for (int k = 0; k < 4; k++) if (m_need[k] > m_cred[k]) m_fits = 0;
    m_ready = reset && renameReady_i && !stall_i && !flush_i && m_fits && (m_blackout == 0);
    m_res   = renameReady_i && !stall_i && !flush_i && !m_ready;
  endfunction

  function automatic void model_edge();
    int fr[4];
    fr[0] = int'(iqFreed_i); fr[1] = int'(robFreed_i);
    fr[2] = int'(ldqFreed_i); fr[3] = int'(stqFreed_i);
    if (flush_i) begin
      for (int k = 0; k < 4; k++) m_cred[k] = m_size[k];
      m_blackout = DRN;
      m_rstall = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int v;
        v = m_cred[k] - (m_ready ? m_need[k] : 0) + fr[k];
        if (v > m_size[k]) begin v = m_size[k]; m_err = 1; end
        m_cred[k] = v;
      end
      if (m_blackout > 0) m_blackout--;
      else if (!m_rstall) m_rstall = renameReady_i && !stall_i && !m_fits;
      else if (m_ready || !renameReady_i) m_rstall = 0;
    end
    if (m_res && m_stall < 64'hFFFF_FFFF) m_stall++;
  endfunction

  task automatic set_in(input logic [3:0] v, input logic [3:0] ld, input logic [3:0] st,
                        input logic [3:0] sk, input logic rr, input logic stl, input logic fl);
    laneValid_i = v; isLoad_i = ld; isStore_i = st; skipIQ_i = sk;
    renameReady_i = rr; stall_i = stl; flush_i = fl;
    iqFreed_i = '0; robFreed_i = '0; ldqFreed_i = '0; stqFreed_i = '0;
  endtask

  // Advance one clock with the model in lockstep; returns 1 ns after the edge.
  task automatic tick();
    model_eval();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(4'hF, 4'h3, 4'h4, 4'h8, 1'b1, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (backEndReady_o !== 1'b0) begin
      bad++; $display("FAIL rst_ready got=%0b want=0", backEndReady_o);
    end
    total++;
    if ({iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o} !== {6'd32, 7'd64, 5'd16, 5'd16}) begin
      bad++; $display("FAIL rst_credits got=%0d/%0d/%0d/%0d want=32/64/16/16",
                      iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o);
    end
    total++;
    if (state_o !== 2'd0 || creditErr_o !== 1'b0 || stallCycles_o !== 32'd0) begin
      bad++; $display("FAIL rst_misc got=%0d/%0b/%0d want=0/0/0",
                      state_o, creditErr_o, stallCycles_o);
    end
    set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_dispatch();
    set_in(4'hF, 4'b0011, 4'b0100, 4'b1000, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (backEndReady_o !== 1'b1 || resStall_o !== 1'b0) begin
      bad++; $display("FAIL disp_ready got=%0b/%0b want=1/0", backEndReady_o, resStall_o);
    end
    tick();
    total++;
    if ({iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o} !== {6'd29, 7'd60, 5'd14, 5'd15}) begin
      bad++; $display("FAIL disp_credits got=%0d/%0d/%0d/%0d want=29/60/14/15",
                      iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o);
    end
  endtask

  task automatic test_ldq_stall();
    repeat (3) begin
      set_in(4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_in(4'b0001, 4'b0001, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if (ldqCredit_o !== 5'd1) begin
      bad++; $display("FAIL ldq_fill got=%0d want=1", ldqCredit_o);
    end
    set_in(4'b0011, 4'b0011, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (backEndReady_o !== 1'b0 || resStall_o !== 1'b1) begin
      bad++; $display("FAIL ldq_block got=%0b/%0b want=0/1", backEndReady_o, resStall_o);
    end
    tick();
    total++;
    if (state_o !== 2'd1) begin
      bad++; $display("FAIL ldq_rstall got=%0d want=1", state_o);
    end
    ldqFreed_i = 3'd1;
    #1;
    total++;
    if (backEndReady_o !== 1'b0) begin
      bad++; $display("FAIL ldq_free_same got=%0b want=0", backEndReady_o);
    end
    tick();
    ldqFreed_i = 3'd0;
    #1;
    total++;
    if (backEndReady_o !== 1'b1 || ldqCredit_o !== 5'd2) begin
      bad++; $display("FAIL ldq_resume got=%0b/%0d want=1/2", backEndReady_o, ldqCredit_o);
    end
    tick();
    total++;
    if (state_o !== 2'd0 || ldqCredit_o !== 5'd0) begin
      bad++; $display("FAIL ldq_run got=%0d/%0d want=0/0", state_o, ldqCredit_o);
    end
  endtask

  task automatic test_flush();
    set_in(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    iqFreed_i = 3'd2;
    #1;
    total++;
    if (backEndReady_o !== 1'b0 || resStall_o !== 1'b0) begin
      bad++; $display("FAIL flush_cycle got=%0b/%0b want=0/0", backEndReady_o, resStall_o);
    end
    tick();
    set_in(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o} !== {6'd32, 7'd64, 5'd16, 5'd16} ||
        state_o !== 2'd2) begin
      bad++; $display("FAIL flush_refill got=%0d/%0d/%0d/%0d st=%0d want=32/64/16/16 st=2",
                      iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o, state_o);
    end
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++;
      if (backEndReady_o !== (c == 3)) begin
        bad++; $display("FAIL flush_drain%0d got=%0b want=%0b", c, backEndReady_o, c == 3);
      end
      tick();
    end
    total++;
    if (iqCredit_o !== 6'd28 || robCredit_o !== 7'd60) begin
      bad++; $display("FAIL flush_after got=%0d/%0d want=28/60", iqCredit_o, robCredit_o);
    end
  endtask

  task automatic test_iq_boundary();
    repeat (6) begin
      set_in(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    iqFreed_i = 3'd4;
    #1;
    total++;
    if (iqCredit_o !== 6'd4 || backEndReady_o !== 1'b1) begin
      bad++; $display("FAIL iq_edge got=%0d/%0b want=4/1", iqCredit_o, backEndReady_o);
    end
    tick();
    total++;
    if (iqCredit_o !== 6'd4 || robCredit_o !== 7'd32) begin
      bad++; $display("FAIL iq_hold got=%0d/%0d want=4/32", iqCredit_o, robCredit_o);
    end
  endtask

  task automatic test_overflow();
    set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    stqFreed_i = 3'd1;
    tick();
    total++;
    if (stqCredit_o !== 5'd16 || creditErr_o !== 1'b1) begin
      bad++; $display("FAIL ovf_set got=%0d/%0b want=16/1", stqCredit_o, creditErr_o);
    end
    set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    flush_i = 1'b0;
    repeat (3) tick();
    total++;
    if (creditErr_o !== 1'b1 || state_o !== 2'd0) begin
      bad++; $display("FAIL ovf_sticky got=%0b/%0d want=1/0", creditErr_o, state_o);
    end
  endtask

  task automatic test_reset_mid();
    repeat (4) begin
      set_in(4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_in(4'b0001, 4'b0001, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    total++;
    if (state_o !== 2'd1 || stallCycles_o !== 32'(m_stall) || ldqCredit_o !== 5'd0) begin
      bad++; $display("FAIL mid_rstall got=%0d/%0d/%0d want=1/%0d/0",
                      state_o, stallCycles_o, ldqCredit_o, m_stall);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o} !== {6'd32, 7'd64, 5'd16, 5'd16} ||
        state_o !== 2'd0 || creditErr_o !== 1'b0 || stallCycles_o !== 32'd0 ||
        backEndReady_o !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%0d/%0d/%0d/%0d st=%0d err=%0b sc=%0d rdy=%0b",
                      iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o, state_o,
                      creditErr_o, stallCycles_o, backEndReady_o);
    end
    model_reset();
    reset = 1'b1;
    #1;
    total++;
    if (backEndReady_o !== 1'b1) begin
      bad++; $display("FAIL mid_release got=%0b want=1", backEndReady_o);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] v, ld, st, sk;
      int cap[4];
      int fr[4];
      v  = 4'($urandom);
      ld = 4'($urandom);
      st = 4'($urandom) & ~ld;
      sk = 4'($urandom) & 4'($urandom);
      set_in(v, ld, st, sk, ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 64) == 0);
      for (int k = 0; k < 4; k++) begin
        cap[k] = m_size[k] - m_cred[k] + ((($urandom % 50) == 0) ? 1 : 0);
        if (cap[k] > W) cap[k] = W;
        fr[k] = int'($urandom_range(0, cap[k]));
      end
      iqFreed_i = 3'(fr[0]); robFreed_i = 3'(fr[1]);
      ldqFreed_i = 3'(fr[2]); stqFreed_i = 3'(fr[3]);
      model_eval();
      #1;
      total++;
      if (backEndReady_o !== m_ready || resStall_o !== m_res) begin
        bad++; $display("FAIL rnd_comb n=%0d got=%0b/%0b want=%0b/%0b",
                        n, backEndReady_o, resStall_o, m_ready, m_res);
      end
      tick();
      total++;
      if ({iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o} !== m_creds() ||
          state_o !== 2'(m_state()) || creditErr_o !== m_err ||
          stallCycles_o !== 32'(m_stall)) begin
        bad++; $display("FAIL rnd_state n=%0d got=%h st=%0d err=%0b sc=%0d want=%h st=%0d err=%0b sc=%0d",
                        n, {iqCredit_o, robCredit_o, ldqCredit_o, stqCredit_o}, state_o,
                        creditErr_o, stallCycles_o, m_creds(), m_state(), m_err, m_stall);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_dispatch();
    test_ldq_stall();
    test_flush();
    test_iq_boundary();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
